param_universal_shift_reg: RTL

- WIDTH-bit universal shift register; parametrised successor to the team's 4-bit universal shift register.
- Adds rotate, arithmetic shift-right and clear modes.
- Adds bidirectional serial in/out.
- Adds a counted multi-shift command with a busy/done handshake, so a datapath can request "shift by K" and wait for completion.

---
 rtl/param_universal_shift_reg.sv | 121 ++++++++++++
 1 files changed

// File: rtl/param_universal_shift_reg.sv
// WIDTH-bit universal shift register with rotate/arith/clear modes and a counted
// multi-shift command (busy/done). Optional even-parity output under USR_PARITY_EN.
module param_universal_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             serialInR,
  input  logic             serialInL,
  input  logic [WIDTH-1:0] BlockIn,
  output logic [WIDTH-1:0] Out,
  output logic             serialOutR,
  output logic             serialOutL,
  output logic             busy,
  output logic             done
`ifdef USR_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam logic [2:0] ModeHold  = 3'b000;
  localparam logic [2:0] ModeShr   = 3'b001;
  localparam logic [2:0] ModeShl   = 3'b010;
  localparam logic [2:0] ModeLoad  = 3'b011;
  localparam logic [2:0] ModeRor   = 3'b100;
  localparam logic [2:0] ModeRol   = 3'b101;
  localparam logic [2:0] ModeAsr   = 3'b110;
  localparam logic [2:0] ModeClear = 3'b111;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] out_q;
  logic [CNT_W-1:0] remaining_q;
  logic [2:0]       mode_q;
  logic             done_q;

  function automatic logic is_shift(input logic [2:0] m);
    return (m == ModeShr) || (m == ModeShl) || (m == ModeRor) ||
           (m == ModeRol) || (m == ModeAsr);
  endfunction

  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0]       m,
                                                input logic [WIDTH-1:0] v,
                                                input logic             sir,
                                                input logic             sil,
                                                input logic [WIDTH-1:0] blk);
    logic [WIDTH-1:0] r;
    r = v;
    unique case (m)
      ModeHold:  r = v;
      ModeShr:   r = {sir, v[WIDTH-1:1]};
      ModeShl:   r = {v[WIDTH-2:0], sil};
      ModeLoad:  r = blk;
      ModeRor:   r = {v[0], v[WIDTH-1:1]};
      ModeRol:   r = {v[WIDTH-2:0], v[WIDTH-1]};
      ModeAsr:   r = {v[WIDTH-1], v[WIDTH-1:1]};
      ModeClear: r = '0;
      default:   r = v;
    endcase
    return r;
  endfunction

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StIdle;
      out_q       <= '0;
      remaining_q <= '0;
      mode_q      <= ModeHold;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && is_shift(mode)) begin
            // The accepting edge performs the first shift; K=0 only pulses done.
            if (count != '0) begin
              out_q <= apply_op(mode, out_q, serialInR, serialInL, BlockIn);
            end
            if (count > CNT_W'(1)) begin
              state_q     <= StRun;
              mode_q      <= mode;
              remaining_q <= count - CNT_W'(1);
            end else begin
              done_q <= 1'b1;
            end
          end else if (en) begin
            out_q <= apply_op(mode, out_q, serialInR, serialInL, BlockIn);
          end
        end
        StRun: begin
          // Serial inputs are sampled live so a stream can be fed mid-command.
          out_q       <= apply_op(mode_q, out_q, serialInR, serialInL, BlockIn);
          remaining_q <= remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Out        = out_q;
  assign serialOutR = out_q[0];
  assign serialOutL = out_q[WIDTH-1];
  assign busy       = (state_q == StRun);
  assign done       = done_q;

`ifdef USR_PARITY_EN
  assign parity = ^out_q;
`endif

endmodule
